// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Shares one single-port instruction/data memory between the fetch unit
//   (read-only) and the load/store unit (read/write). One transaction is
//   outstanding at a time, and each response is routed back to the requester
//   that issued it. A fetch flush drops any stale instruction response.
//
// Optional feature (build macro MEM_ARB_STARVE_GUARD_EN):
//   Counts consecutive load/store grants made while a fetch is waiting. After
//   STARVE_LIMIT of them, the next contested grant goes to fetch.
//
// Ports:
//   clk, rst                      clock (rising edge); async active-high reset
//   if_req_*                      fetch request (valid/addr) with ready
//   if_flush                      discard any in-flight fetch
//   if_resp_valid/data            registered fetch response, one-cycle pulse
//   ls_req_*                      load/store request (valid/we/addr/wdata/wstrb)
//                                 with ready
//   ls_resp_valid/data            registered load data or store ack
//                                 (data is 0 for stores)
//   mem_req/we/addr/wdata/wstrb   memory request, held stable until mem_gnt
//   mem_gnt, mem_rvalid, mem_rdata memory handshake and response
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req_valid,
    input  logic [XLEN-1:0]     if_req_addr,
    output logic                if_req_ready,
    input  logic                if_flush,
    output logic                if_resp_valid,
    output logic [XLEN-1:0]     if_resp_data,
    input  logic                ls_req_valid,
    input  logic                ls_req_we,
    input  logic [XLEN-1:0]     ls_req_addr,
    input  logic [XLEN-1:0]     ls_req_wdata,
    input  logic [XLEN/8-1:0]   ls_req_wstrb,
    output logic                ls_req_ready,
    output logic                ls_resp_valid,
    output logic [XLEN-1:0]     ls_resp_data,
    output logic                mem_req,
    output logic                mem_we,
    output logic [XLEN-1:0]     mem_addr,
    output logic [XLEN-1:0]     mem_wdata,
    output logic [XLEN/8-1:0]   mem_wstrb,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [XLEN-1:0]     mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next;

    logic [XLEN-1:0]       r_addr;
    logic                  r_we;
    logic [XLEN-1:0]       r_wdata;
    logic [XLEN/8-1:0]     r_wstrb;
    logic                  r_owner;   // 0 = fetch, 1 = load/store
    logic                  r_drop;    // fetch flushed while waiting for data
    logic                  r_if_resp_valid;
    logic [XLEN-1:0]       r_if_resp_data;
    logic                  r_ls_resp_valid;
    logic [XLEN-1:0]       r_ls_resp_data;

    logic                  w_idle;
    logic                  w_if_ok;
    logic                  w_force_if;
    logic                  w_ls_acc;
    logic                  w_if_acc;

    // Ready is held low during reset so that every output reads 0 while rst=1.
    assign w_idle  = (r_state == IDLE) && !rst;
    // A fetch presented together with a flush is stale; it is never accepted.
    assign w_if_ok = if_req_valid && !if_flush;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int unsigned STREAK_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);

    logic [STREAK_W-1:0]   r_ls_streak;

    assign w_force_if = (r_ls_streak == STREAK_MAX) && w_if_ok && ls_req_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ls_streak <= '0;
        end else if (w_ls_acc && if_req_valid) begin
            // Saturate: a flushed fetch can let ls win again at the limit.
            if (r_ls_streak != STREAK_MAX) begin
                r_ls_streak <= r_ls_streak + 1'b1;
            end
        end else if (w_if_acc || ((r_state == IDLE) && !if_req_valid)) begin
            r_ls_streak <= '0;
        end
    end
`else
    assign w_force_if = 1'b0;
`endif

    assign w_ls_acc     = w_idle && ls_req_valid && !w_force_if;
    assign w_if_acc     = w_idle && w_if_ok && !w_ls_acc;
    assign ls_req_ready = w_ls_acc;
    assign if_req_ready = w_if_acc;

    assign mem_req       = (r_state == REQ);
    assign mem_we        = r_we;
    assign mem_addr      = r_addr;
    assign mem_wdata     = r_wdata;
    assign mem_wstrb     = r_wstrb;
    assign if_resp_valid = r_if_resp_valid;
    assign if_resp_data  = r_if_resp_data;
    assign ls_resp_valid = r_ls_resp_valid;
    assign ls_resp_data  = r_ls_resp_data;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_ls_acc || w_if_acc) begin
                    w_next = REQ;
                end
            end
            REQ: begin
                // A grant takes priority over a flush: the memory has already
                // committed, so the response must still be consumed in WAIT.
                if (mem_gnt) begin
                    w_next = WAIT;
                end else if (!r_owner && if_flush) begin
                    w_next = IDLE;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= IDLE;
            r_addr          <= '0;
            r_we            <= 1'b0;
            r_wdata         <= '0;
            r_wstrb         <= '0;
            r_owner         <= 1'b0;
            r_drop          <= 1'b0;
            r_if_resp_valid <= 1'b0;
            r_if_resp_data  <= '0;
            r_ls_resp_valid <= 1'b0;
            r_ls_resp_data  <= '0;
        end else begin
            r_state         <= w_next;
            r_if_resp_valid <= 1'b0;
            r_ls_resp_valid <= 1'b0;

            if (w_ls_acc) begin
                r_addr  <= ls_req_addr;
                r_we    <= ls_req_we;
                r_wdata <= ls_req_wdata;
                r_wstrb <= ls_req_wstrb;
                r_owner <= 1'b1;
            end else if (w_if_acc) begin
                r_addr  <= if_req_addr;
                r_we    <= 1'b0;
                r_wdata <= '0;
                r_wstrb <= '0;
                r_owner <= 1'b0;
            end

            case (r_state)
                REQ: begin
                    if (mem_gnt && !r_owner && if_flush) begin
                        r_drop <= 1'b1;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        r_drop <= 1'b0;
                        if (r_owner) begin
                            r_ls_resp_valid <= 1'b1;
                            r_ls_resp_data  <= r_we ? '0 : mem_rdata;
                        end else if (!(r_drop || if_flush)) begin
                            r_if_resp_valid <= 1'b1;
                            r_if_resp_data  <= mem_rdata;
                        end
                    end else if (!r_owner && if_flush) begin
                        r_drop <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed self-checking bench for mem_arbiter. A small memory model grants
//   combinationally (gnt_en) and returns rvalid one cycle after a grant
//   (auto_rv); force_rv injects a response by hand.
//   Inputs are driven 1 time unit after the rising edge and outputs are
//   sampled 1 time unit later.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int unsigned XLEN = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req_valid;
    logic [XLEN-1:0]   if_req_addr;
    logic              if_req_ready;
    logic              if_flush;
    logic              if_resp_valid;
    logic [XLEN-1:0]   if_resp_data;
    logic              ls_req_valid;
    logic              ls_req_we;
    logic [XLEN-1:0]   ls_req_addr;
    logic [XLEN-1:0]   ls_req_wdata;
    logic [XLEN/8-1:0] ls_req_wstrb;
    logic              ls_req_ready;
    logic              ls_resp_valid;
    logic [XLEN-1:0]   ls_resp_data;
    logic              mem_req;
    logic              mem_we;
    logic [XLEN-1:0]   mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [XLEN/8-1:0] mem_wstrb;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [XLEN-1:0]   mem_rdata;

    logic              gnt_en;
    logic              auto_rv;
    logic              force_rv;
    logic [XLEN-1:0]   mem_data;
    logic              r_rv;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr),
        .if_req_ready(if_req_ready), .if_flush(if_flush),
        .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
        .ls_req_valid(ls_req_valid), .ls_req_we(ls_req_we),
        .ls_req_addr(ls_req_addr), .ls_req_wdata(ls_req_wdata),
        .ls_req_wstrb(ls_req_wstrb), .ls_req_ready(ls_req_ready),
        .ls_resp_valid(ls_resp_valid), .ls_resp_data(ls_resp_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    // Memory model
    assign mem_gnt    = mem_req && gnt_en;
    assign mem_rvalid = r_rv || force_rv;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rv      <= 1'b0;
            mem_rdata <= '0;
        end else begin
            r_rv      <= auto_rv && mem_req && mem_gnt;
            mem_rdata <= mem_data;
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [XLEN-1:0] obs,
                         input logic [XLEN-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_req"},  {31'd0, mem_req},       '0);
        check({tag, "_mem_we"},   {31'd0, mem_we},        '0);
        check({tag, "_mem_addr"}, mem_addr,               '0);
        check({tag, "_mem_wdata"}, mem_wdata,             '0);
        check({tag, "_mem_wstrb"}, {28'd0, mem_wstrb},    '0);
        check({tag, "_ready"},    {30'd0, if_req_ready, ls_req_ready}, '0);
        check({tag, "_resp_v"},   {30'd0, if_resp_valid, ls_resp_valid}, '0);
        check({tag, "_if_data"},  if_resp_data,           '0);
        check({tag, "_ls_data"},  ls_resp_data,           '0);
    endtask

    // Hard stop in case the sequence wedges
    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic got;
        logic exp_if;

        rst = 1'b1;
        if_req_valid = 1'b0; if_req_addr = '0; if_flush = 1'b0;
        ls_req_valid = 1'b0; ls_req_we = 1'b0; ls_req_addr = '0;
        ls_req_wdata = '0; ls_req_wstrb = '0;
        gnt_en = 1'b1; auto_rv = 1'b1; force_rv = 1'b0; mem_data = '0;

        // Reset: everything 0 even with requests present
        step; step;
        ls_req_valid = 1'b1; if_req_valid = 1'b1;
        #1;
        check_all_zero("reset");
        ls_req_valid = 1'b0; if_req_valid = 1'b0;
        step;
        rst = 1'b0;

        // Single fetch, minimum latency
        step;
        if_req_valid = 1'b1; if_req_addr = 32'h100; mem_data = 32'h0000_0013;
        #1 check("f1_if_ready_T", {31'd0, if_req_ready}, 32'd1);
        step; if_req_valid = 1'b0;                                  // T+1
        #1 check("f1_mem_req_T1", {31'd0, mem_req}, 32'd1);
        check("f1_mem_addr_T1", mem_addr, 32'h100);
        check("f1_mem_we_T1", {31'd0, mem_we}, 32'd0);
        step;                                                       // T+2
        #1 check("f1_mem_req_T2", {31'd0, mem_req}, 32'd0);
        check("f1_no_resp_T2", {31'd0, if_resp_valid}, 32'd0);
        step;                                                       // T+3
        #1 check("f1_if_resp_v_T3", {31'd0, if_resp_valid}, 32'd1);
        check("f1_if_resp_d_T3", if_resp_data, 32'h0000_0013);
        step;
        #1 check("f1_if_resp_pulse", {31'd0, if_resp_valid}, 32'd0);
        check("f1_if_data_hold", if_resp_data, 32'h0000_0013);

        // Simultaneous fetch and load: ls first
        if_req_valid = 1'b1; if_req_addr = 32'h200;
        ls_req_valid = 1'b1; ls_req_we = 1'b0; ls_req_addr = 32'h1000;
        mem_data = 32'hAAAA_0001;
        #1 check("s_ready_T", {30'd0, if_req_ready, ls_req_ready}, 32'd1);
        step; ls_req_valid = 1'b0;                                  // T+1
        #1 check("s_mem_addr_ls", mem_addr, 32'h1000);
        check("s_if_wait", {31'd0, if_req_ready}, 32'd0);
        step; mem_data = 32'h0000_0093;                             // T+2
        step;                                                       // T+3
        #1 check("s_ls_resp_v", {31'd0, ls_resp_valid}, 32'd1);
        check("s_ls_resp_d", ls_resp_data, 32'hAAAA_0001);
        check("s_if_ready_T3", {31'd0, if_req_ready}, 32'd1);
        step; if_req_valid = 1'b0;                                  // T+4
        #1 check("s_mem_addr_if", mem_addr, 32'h200);
        step; step;                                                 // T+6
        #1 check("s_if_resp_v_T6", {31'd0, if_resp_valid}, 32'd1);
        check("s_if_resp_d_T6", if_resp_data, 32'h0000_0093);
        check("s_ls_no_resp", {31'd0, ls_resp_valid}, 32'd0);

        // Store held through three cycles without grant
        step;
        gnt_en = 1'b0; mem_data = 32'h1234_5678;
        ls_req_valid = 1'b1; ls_req_we = 1'b1; ls_req_addr = 32'h2004;
        ls_req_wdata = 32'hDEAD_BEEF; ls_req_wstrb = 4'hF;
        #1 check("st_ready", {31'd0, ls_req_ready}, 32'd1);
        step;
        ls_req_valid = 1'b0; ls_req_we = 1'b0; ls_req_addr = '0;
        ls_req_wdata = '0; ls_req_wstrb = '0;
        for (int i = 0; i < 3; i++) begin
            #1 check("st_hold_req", {31'd0, mem_req}, 32'd1);
            check("st_hold_we", {31'd0, mem_we}, 32'd1);
            check("st_hold_addr", mem_addr, 32'h2004);
            check("st_hold_wdata", mem_wdata, 32'hDEAD_BEEF);
            check("st_hold_wstrb", {28'd0, mem_wstrb}, 32'hF);
            step;
        end
        gnt_en = 1'b1;
        #1 check("st_req_at_gnt", {31'd0, mem_req}, 32'd1);
        step;                                                       // WAIT
        #1 check("st_no_resp_yet", {31'd0, ls_resp_valid}, 32'd0);
        step;
        #1 check("st_ls_resp_v", {31'd0, ls_resp_valid}, 32'd1);
        check("st_ls_resp_d0", ls_resp_data, 32'd0);

        // Flush during WAIT drops the fetch response
        step;
        auto_rv = 1'b0;
        if_req_valid = 1'b1; if_req_addr = 32'h300;
        #1 check("fw_ready", {31'd0, if_req_ready}, 32'd1);
        step; if_req_valid = 1'b0;                                  // REQ, gnt
        step; if_flush = 1'b1; mem_data = 32'h0000_0055;            // WAIT
        #1 check("fw_wait_no_req", {31'd0, mem_req}, 32'd0);
        step; if_flush = 1'b0; force_rv = 1'b1;                     // rvalid
        step; force_rv = 1'b0;
        #1 check("fw_dropped", {31'd0, if_resp_valid}, 32'd0);
        check("fw_data_held", if_resp_data, 32'h0000_0093);
        auto_rv = 1'b1; mem_data = 32'h0000_0066;
        if_req_valid = 1'b1; if_req_addr = 32'h304;
        #1 check("fw_new_ready", {31'd0, if_req_ready}, 32'd1);
        step; if_req_valid = 1'b0;
        step; step;
        #1 check("fw_new_resp_v", {31'd0, if_resp_valid}, 32'd1);
        check("fw_new_resp_d", if_resp_data, 32'h0000_0066);

        // Flush blocks fetch acceptance; flush in REQ abandons
        step;
        gnt_en = 1'b0;
        if_req_valid = 1'b1; if_req_addr = 32'h400; if_flush = 1'b1;
        #1 check("fr_flush_blocks", {31'd0, if_req_ready}, 32'd0);
        if_flush = 1'b0;
        #1 check("fr_ready", {31'd0, if_req_ready}, 32'd1);
        step; if_req_valid = 1'b0; if_flush = 1'b1;                 // REQ
        #1 check("fr_in_req", {31'd0, mem_req}, 32'd1);
        step; if_flush = 1'b0; gnt_en = 1'b1;
        #1 check("fr_abandon", {31'd0, mem_req}, 32'd0);
        step;
        #1 check("fr_still_idle", {31'd0, mem_req}, 32'd0);
        check("fr_no_resp", {31'd0, if_resp_valid}, 32'd0);

        // Reset mid-WAIT; a late rvalid is ignored
        auto_rv = 1'b0;
        ls_req_valid = 1'b1; ls_req_we = 1'b0; ls_req_addr = 32'h3000;
        #1 check("rw_ready", {31'd0, ls_req_ready}, 32'd1);
        step; ls_req_valid = 1'b0;
        step;                                                       // WAIT
        rst = 1'b1;
        #1 check_all_zero("rst_wait");
        step; rst = 1'b0; force_rv = 1'b1; mem_data = 32'hBAD0_0001;
        step; force_rv = 1'b0;
        #1 check("rw_late_rv", {30'd0, if_resp_valid, ls_resp_valid}, 32'd0);
        check("rw_late_data", ls_resp_data, 32'd0);

        // Both requesters continuously valid
        auto_rv = 1'b1; gnt_en = 1'b1;
        if_req_valid = 1'b1; if_req_addr = 32'h600;
        ls_req_valid = 1'b1; ls_req_we = 1'b0; ls_req_addr = 32'h700;
        #1;
        for (int n = 0; n < 6; n++) begin
            got = 1'b0;
            for (int c = 0; c < 6 && !got; c++) begin
                if (ls_req_ready || if_req_ready) got = 1'b1;
                else step;
            end
            if (!got) check("sv_timeout", 32'd0, 32'd1);
`ifdef MEM_ARB_STARVE_GUARD_EN
            exp_if = (n == 4);
`else
            exp_if = 1'b0;
`endif
            check("sv_grant_is_if", {31'd0, if_req_ready}, {31'd0, exp_if});
            check("sv_one_grant", {31'd0, if_req_ready ^ ls_req_ready}, 32'd1);
            step;
        end
        if_req_valid = 1'b0; ls_req_valid = 1'b0;
        repeat (4) step;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
